shift_frame_ctrl: RTL and testbench

//  Sequences one WIDTH-bit frame at a time through the serial shift register: accepts a

---
 rtl/shift_frame_ctrl_pkg.sv | 19 +
 rtl/shift_frame_ctrl_if.sv | 33 +++
 rtl/shift_frame_ctrl_bit_counter.sv | 37 +++
 rtl/shift_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_shift_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_frame_ctrl_pkg.sv
// Shared definitions for the serial frame controller.
//   state_t      : 2-bit controller state encoding (IDLE, SHIFT, CAPTURE, HOLD)
//   count_width  : bit count width for a given frame length
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // A frame of WIDTH bits needs a counter that reaches WIDTH-1. WIDTH is at
  // least 2, but keep the counter at least one bit wide regardless.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Bundle of the word-side handshakes and the shift register hookup for
// shift_frame_ctrl.
//   in_valid/in_data/in_ready    : word input from the producer
//   ser_bit/ser_en               : serial drive into shift_reg.shift_in
//   sr_data                      : shift_reg.data_out, read back at capture
//   out_valid/out_data/out_ready : captured frame to the consumer
//   busy/err                     : status
// master is the controller's view, slave is the surrounding environment.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_en;
  logic [WIDTH-1:0] sr_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
  logic             err;

  modport master (
    input  in_valid, in_data, sr_data, out_ready,
    output in_ready, ser_bit, ser_en, out_valid, out_data, busy, err
  );

  modport slave (
    output in_valid, in_data, sr_data, out_ready,
    input  in_ready, ser_bit, ser_en, out_valid, out_data, busy, err
  );
endinterface

// File: rtl/shift_frame_ctrl_bit_counter.sv
// Bit counter for one serial frame.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : return the count to zero (takes priority over enable)
//   enable     : advance by one; the count holds once it reaches WIDTH-1
//   last       : count == WIDTH-1
module shift_bit_counter
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Saturate at WIDTH-1 so the count can never wrap while SHIFT is still
  // deciding whether to leave.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer between a word-level producer/consumer and an external
// shift_reg. It accepts a word, drives it bit-serially on ser_bit for WIDTH
// cycles, captures the register's parallel output, and holds it for the
// consumer.
//   clk, reset : clock shared with shift_reg, asynchronous active-high reset
//   bus        : shift_frame_ctrl_if.master (handshakes, serial drive, status)
// Parameters: WIDTH (frame bits), MSB_FIRST (bit order), IDLE_BIT (ser_bit
// value while ser_en is low).
// Build option: define LOOPBACK_CHECK_EN to compare the captured frame with
// the accepted word and raise a sticky err on mismatch; otherwise err is 0.
module shift_frame_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  shift_frame_ctrl_if.master bus
);

  state_t           state;
  logic [WIDTH-1:0] shift_word;
  logic             ser_bit_q;
  logic             ser_en_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             accept;
  logic             last;

  // Bit that goes on the wire next, taken from the leading end of the word.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the leading bit so the following one moves into its place.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && in_ready_q;

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == SHIFT),
    .last   (last)
  );

  // All outputs are registered. ser_bit is loaded one edge ahead of the
  // cycle it is driven, so the first bit leaves straight from in_data at
  // accept and the stored shift word is already advanced past it. The
  // count therefore tracks the bit currently on ser_bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_word  <= '0;
      ser_bit_q   <= IDLE_BIT;
      ser_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            shift_word <= advance(bus.in_data);
            ser_bit_q  <= lead_bit(bus.in_data);
            ser_en_q   <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (last) begin
            state     <= CAPTURE;
            ser_en_q  <= 1'b0;
            ser_bit_q <= IDLE_BIT;
          end else begin
            ser_bit_q  <= lead_bit(shift_word);
            shift_word <= advance(shift_word);
          end
        end
        CAPTURE: begin
          // The register took its last bit on the edge that entered CAPTURE.
          out_data_q  <= bus.sr_data;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_en    = ser_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

`ifdef LOOPBACK_CHECK_EN
  logic [WIDTH-1:0] kept_word;
  logic [WIDTH-1:0] expect_sr;
  logic             err_q;

  // LSB-first shifting lands the word reversed in the register.
  always_comb begin
    expect_sr = kept_word;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        expect_sr[i] = kept_word[WIDTH-1-i];
      end
    end
  end

  // err is sticky; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kept_word <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        kept_word <= bus.in_data;
      end
      if ((state == CAPTURE) && (bus.sr_data != expect_sr)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl. Two controllers are used: dut_a
// sends MSB first and dut_b sends LSB first. Each one drives a behavioural
// shift register that shifts left and takes ser_bit into bit 0. Expected
// serial bits and captured frames are worked out from each word by the
// functions below.
module tb_shift_frame_ctrl;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic corrupt_a;
  logic [W-1:0] sr_a;
  logic [W-1:0] sr_b;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  shift_frame_ctrl_if #(.WIDTH(W)) bus_a ();
  shift_frame_ctrl_if #(.WIDTH(W)) bus_b ();

  shift_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.master)
  );

  shift_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial-in register that the controllers drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      if (bus_a.ser_en) sr_a <= {sr_a[W-2:0], bus_a.ser_bit};
      if (bus_b.ser_en) sr_b <= {sr_b[W-2:0], bus_b.ser_bit};
    end
  end

  assign bus_a.sr_data = sr_a ^ {{(W-1){1'b0}}, corrupt_a};
  assign bus_b.sr_data = sr_b;

  function automatic logic expectedBit(input logic [W-1:0] w, input int i, input bit msb_first);
    return msb_first ? w[W-1-i] : w[i];
  endfunction

  function automatic logic [W-1:0] captureOf(input logic [W-1:0] w, input bit msb_first);
    logic [W-1:0] r;
    r = w;
    if (!msb_first) begin
      for (int j = 0; j < W; j++) r[j] = w[W-1-j];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One full frame through dut_a, starting and ending at a negedge.
  // ready_delay is the number of HOLD cycles with out_ready low.
  task automatic applyStimulus(input logic [W-1:0] word, input int ready_delay, input bit corrupt);
    int wait_cnt;
    logic [W-1:0] frame;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = word;
    bus_a.out_ready = (ready_delay == 0);
    corrupt_a       = corrupt;
    wait_cnt = 0;
    while (!bus_a.in_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus_a.in_ready) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      bus_a.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(captureOf(word, 1'b1) ^ {{(W-1){1'b0}}, corrupt});
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = W'($urandom);
    for (int i = 0; i < W; i++) begin
      checkOutput("serEn", 32'(bus_a.ser_en), 32'd1);
      checkOutput("serBit", 32'(bus_a.ser_bit), 32'(expectedBit(word, i, 1'b1)));
      if (i == 0) checkOutput("inReadyLow", 32'(bus_a.in_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("serEnDone", 32'(bus_a.ser_en), 32'd0);
    checkOutput("serBitIdle", 32'(bus_a.ser_bit), 32'd0);
    checkOutput("noEarlyValid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("busyCapture", 32'(bus_a.busy), 32'd1);
    @(negedge clk);
    corrupt_a = 1'b0;
    frame = exp_q.pop_front();
    checkOutput("outValid", 32'(bus_a.out_valid), 32'd1);
    checkOutput("outData", 32'(bus_a.out_data), 32'(frame));
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      checkOutput("outValidHold", 32'(bus_a.out_valid), 32'd1);
      checkOutput("outDataHold", 32'(bus_a.out_data), 32'(frame));
      checkOutput("inReadyHold", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("outValidDrop", 32'(bus_a.out_valid), 32'd0);
    checkOutput("inReadyBack", 32'(bus_a.in_ready), 32'd1);
    checkOutput("busyIdle", 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen_valid;
    logic seen_en;
    logic exp_err;
    int wait_cnt;
    total = 0;
    bad = 0;
`ifdef LOOPBACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset = 1'b1;
    corrupt_a = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data = 8'h77;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0;
    bus_b.in_data = '0;
    bus_b.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, with a handshake offered that must not be taken.
    checkOutput("rstInReady", 32'(bus_a.in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(bus_a.out_valid), 32'd0);
    checkOutput("rstSerEn", 32'(bus_a.ser_en), 32'd0);
    checkOutput("rstSerBit", 32'(bus_a.ser_bit), 32'd0);
    checkOutput("rstBusy", 32'(bus_a.busy), 32'd0);
    checkOutput("rstErr", 32'(bus_a.err), 32'd0);
    checkOutput("rstOutData", 32'(bus_a.out_data), 32'd0);
    checkOutput("rstInReadyB", 32'(bus_b.in_ready), 32'd1);
    bus_a.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed frames");
    applyStimulus(8'hA5, 0, 1'b0);
    applyStimulus(8'h3C, 5, 1'b0);

    $display("[TB] reset mid-frame");
    bus_a.in_valid = 1'b1;
    bus_a.in_data = 8'hFF;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midRstInReady", 32'(bus_a.in_ready), 32'd1);
    checkOutput("midRstSerEn", 32'(bus_a.ser_en), 32'd0);
    checkOutput("midRstBusy", 32'(bus_a.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_valid = 1'b0;
    seen_en = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      seen_valid |= bus_a.out_valid;
      seen_en |= bus_a.ser_en;
    end
    checkOutput("abandonNoValid", 32'(seen_valid), 32'd0);
    checkOutput("abandonNoShift", 32'(seen_en), 32'd0);
    applyStimulus(8'h01, 0, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 10; n++) begin
      applyStimulus(W'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] loopback corruption");
    checkOutput("errBefore", 32'(bus_a.err), 32'd0);
    applyStimulus(8'h5A, 0, 1'b1);
    checkOutput("errAfterBad", 32'(bus_a.err), 32'(exp_err));
    applyStimulus(8'hC3, 1, 1'b0);
    checkOutput("errSticky", 32'(bus_a.err), 32'(exp_err));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("errCleared", 32'(bus_a.err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] LSB-first back-to-back");
    bus_b.out_ready = 1'b1;
    bus_b.in_valid = 1'b1;
    bus_b.in_data = 8'h01;
    wait_cnt = 0;
    while (!bus_b.in_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("bAcceptReady", 32'(bus_b.in_ready), 32'd1);
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      checkOutput("bSerEn", 32'(bus_b.ser_en), 32'd1);
      checkOutput("bSerBit", 32'(bus_b.ser_bit), 32'(expectedBit(8'h01, i, 1'b0)));
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput("bOutValid", 32'(bus_b.out_valid), 32'd1);
    checkOutput("bOutData", 32'(bus_b.out_data), 32'(captureOf(8'h01, 1'b0)));
    bus_b.in_data = 8'h80;
    @(negedge clk);
    checkOutput("bOutDrop", 32'(bus_b.out_valid), 32'd0);
    checkOutput("bInReady", 32'(bus_b.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("bSecondEn", 32'(bus_b.ser_en), 32'd1);
    checkOutput("bSecondBit0", 32'(bus_b.ser_bit), 32'(expectedBit(8'h80, 0, 1'b0)));
    checkOutput("bSecondBusy", 32'(bus_b.in_ready), 32'd0);
    bus_b.in_valid = 1'b0;
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      checkOutput("bSecondBit", 32'(bus_b.ser_bit), 32'(expectedBit(8'h80, i, 1'b0)));
    end
    repeat (2) @(negedge clk);
    checkOutput("bSecondValid", 32'(bus_b.out_valid), 32'd1);
    checkOutput("bSecondData", 32'(bus_b.out_data), 32'(captureOf(8'h80, 1'b0)));
    checkOutput("bErr", 32'(bus_b.err), 32'd0);
    @(negedge clk);
    checkOutput("bSecondDrop", 32'(bus_b.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
